// File: rtl/reg_scoreboard_pkg.sv
// ============================================================================
// Module      : reg_scoreboard_pkg
// Description : Shared RISC-V definitions: opcode constants, pending-count
//               width and register-file geometry for the register scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_scoreboard_pkg;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int OPC_W    = 7;
    localparam int CNT_W    = 2;

    typedef logic [CNT_W-1:0]  cnt_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [OPC_W-1:0]  opcode_t;

    localparam cnt_t CNT_MAX = '1;

    localparam opcode_t OPC_LOAD   = 7'b0000011;
    localparam opcode_t OPC_STORE  = 7'b0100011;
    localparam opcode_t OPC_BRANCH = 7'b1100011;
    localparam opcode_t OPC_OP     = 7'b0110011;
    localparam opcode_t OPC_OP_IMM = 7'b0010011;
    localparam opcode_t OPC_JAL    = 7'b1101111;
    localparam opcode_t OPC_JALR   = 7'b1100111;
    localparam opcode_t OPC_LUI    = 7'b0110111;
    localparam opcode_t OPC_AUIPC  = 7'b0010111;

    // STORE and BRANCH carry no destination, their rd field is an immediate.
    function automatic logic opcode_writes_rd(input opcode_t opc);
        return (opc != OPC_STORE) && (opc != OPC_BRANCH);
    endfunction

endpackage : reg_scoreboard_pkg

`default_nettype wire

// File: rtl/reg_scoreboard_if.sv
// ============================================================================
// Module      : reg_scoreboard_if
// Description : Decode check, issue, writeback and kill buses of the register
//               scoreboard, with the hazard and status outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface reg_scoreboard_if;
    import reg_scoreboard_pkg::*;

    logic      chk_rs1_valid;
    reg_addr_t chk_rs1_addr;
    logic      chk_rs2_valid;
    reg_addr_t chk_rs2_addr;
    logic      issue_valid;
    reg_addr_t issue_rd_addr;
    opcode_t   issue_opcode;
    logic      wb_valid;
    reg_addr_t wb_rd_addr;
    logic      kill_valid;
    reg_addr_t kill_rd_addr;
    logic      stall;
    logic      busy;
    logic      underflow_err;

    modport master (
        output chk_rs1_valid, chk_rs1_addr, chk_rs2_valid, chk_rs2_addr,
        output issue_valid, issue_rd_addr, issue_opcode,
        output wb_valid, wb_rd_addr, kill_valid, kill_rd_addr,
        input  stall, busy, underflow_err
    );

    modport slave (
        input  chk_rs1_valid, chk_rs1_addr, chk_rs2_valid, chk_rs2_addr,
        input  issue_valid, issue_rd_addr, issue_opcode,
        input  wb_valid, wb_rd_addr, kill_valid, kill_rd_addr,
        output stall, busy, underflow_err
    );

endinterface : reg_scoreboard_if

`default_nettype wire

// File: rtl/reg_scoreboard_entry.sv
// ============================================================================
// Module      : scoreboard_entry
// Description : Pending-write counter for one architectural register, with a
//               saturating increment and clamped, flagged decrement.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scoreboard_entry
    import reg_scoreboard_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       inc_i,
    input  wire logic [1:0] dec_i,
    output cnt_t            count_o,
    output cnt_t            count_next_o,
    output logic            underflow_o
);

    localparam int SUM_W = CNT_W + 1;

    cnt_t             count_q;
    cnt_t             count_d;
    logic             w_inc_eff;
    logic [SUM_W-1:0] w_sum;
    logic [SUM_W-1:0] w_dec;

    // A full counter ignores the increment; upstream re-presents that issue.
    always_comb begin
        w_inc_eff   = inc_i && (count_q != CNT_MAX);
        w_sum       = {1'b0, count_q} + SUM_W'(w_inc_eff);
        w_dec       = SUM_W'(dec_i);
        underflow_o = (w_sum < w_dec);
        count_d     = underflow_o ? '0 : CNT_W'(w_sum - w_dec);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o      = count_q;
    assign count_next_o = count_d;

endmodule : scoreboard_entry

`default_nettype wire

// File: rtl/reg_scoreboard.sv
// ============================================================================
// Module      : reg_scoreboard
// Description : Register scoreboard tracking in-flight writers of x1..x31 and
//               raising a decode stall on RAW hazards or a full counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_scoreboard
    import reg_scoreboard_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst,
    reg_scoreboard_if.slave  sb
);

    cnt_t                count      [NUM_REGS];
    cnt_t                count_next [NUM_REGS];
    logic [NUM_REGS-1:0] w_nz_next;
    logic [NUM_REGS-1:0] w_uflow;
    logic                w_issue_track;
    logic                w_stall;
    logic                busy_q;
    logic                underflow_q;

    assign w_issue_track = sb.issue_valid && (sb.issue_rd_addr != '0)
                           && opcode_writes_rd(sb.issue_opcode);

    // x0 is hardwired to an empty entry so any x0 lookup reads zero.
    assign count[0]      = '0;
    assign count_next[0] = '0;
    assign w_nz_next[0]  = 1'b0;
    assign w_uflow[0]    = 1'b0;

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_entry
        logic       w_inc;
        logic       w_wb_hit;
        logic       w_kill_hit;
        logic [1:0] w_dec;

        assign w_inc      = w_issue_track && (sb.issue_rd_addr == ADDR_W'(i));
        assign w_wb_hit   = sb.wb_valid   && (sb.wb_rd_addr   == ADDR_W'(i));
        assign w_kill_hit = sb.kill_valid && (sb.kill_rd_addr == ADDR_W'(i));
        assign w_dec      = {1'b0, w_wb_hit} + {1'b0, w_kill_hit};

        scoreboard_entry u_entry (
            .clk          (clk),
            .rst          (rst),
            .inc_i        (w_inc),
            .dec_i        (w_dec),
            .count_o      (count[i]),
            .count_next_o (count_next[i]),
            .underflow_o  (w_uflow[i])
        );

        assign w_nz_next[i] = (count_next[i] != '0);
    end

    // Current state only: a same-cycle writeback does not release the stall.
    always_comb begin
        w_stall = 1'b0;
        if (!rst) begin
            w_stall = (sb.chk_rs1_valid && (count[sb.chk_rs1_addr] != '0))
                   || (sb.chk_rs2_valid && (count[sb.chk_rs2_addr] != '0))
                   || (w_issue_track && (count[sb.issue_rd_addr] == CNT_MAX));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q      <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            busy_q      <= |w_nz_next;
            underflow_q <= underflow_q | (|w_uflow);
        end
    end

    assign sb.stall         = w_stall;
    assign sb.busy          = busy_q;
    assign sb.underflow_err = underflow_q;

endmodule : reg_scoreboard

`default_nettype wire

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have ports: clk input 1, rising-edge clock; rst input 1, reset, asynchronous, active-high.
REQ-002 SHALL have chk_rs1_valid input 1 and chk_rs1_addr input 5: decode-stage source 1 in use, and its address.
REQ-003 SHALL have chk_rs2_valid input 1 and chk_rs2_addr input 5: decode-stage source 2 in use, and its address.
REQ-004 SHALL have issue_valid input 1, issue_rd_addr input 5 and issue_opcode input 7: an instruction enters the ID/EX register this cycle, with its destination and opcode.
REQ-005 SHALL have wb_valid input 1 and wb_rd_addr input 5: an instruction commits its rd write this cycle.
REQ-006 SHALL have kill_valid input 1 and kill_rd_addr input 5: an in-flight writer is squashed by a flush this cycle.
REQ-007 SHALL have stall output 1: decode must hold.
REQ-008 SHALL have busy output 1: any register is pending.
REQ-009 SHALL have underflow_err output 1: sticky protocol-error flag.

Function
REQ-010 SHALL keep a 2-bit pending count per register x1..x31; x0 SHALL never be tracked and SHALL always read count 0.
REQ-011 An issue SHALL be tracked only when issue_valid=1, issue_rd_addr!=0, and issue_opcode is not STORE (0100011) or BRANCH (1100011).
REQ-012 A tracked issue SHALL increment count[issue_rd_addr] at the next clk edge.
REQ-013 wb_valid with a nonzero address SHALL decrement count[wb_rd_addr]; kill_valid SHALL decrement count[kill_rd_addr] in the same way.
REQ-014 Simultaneous events on one register SHALL apply the net sum in one cycle, e.g. +1-1=unchanged, +1-2=-1.
REQ-015 A decrement that would take a count below 0 SHALL leave the count at 0 and set underflow_err=1; underflow_err SHALL stay 1 until reset.
REQ-016 stall SHALL be combinational from current state only, with no same-cycle wb bypass: stall=1 if (chk_rs1_valid and count[chk_rs1_addr]!=0) or (chk_rs2_valid and count[chk_rs2_addr]!=0) or (a tracked issue targets a register whose count is 3).
REQ-017 When a tracked issue targets a register whose count is 3, that count SHALL NOT change; the upstream stage SHALL re-present the issue while stall=1.
REQ-018 A source address of 0 SHALL never cause a stall.
REQ-019 busy SHALL be 1 iff any count!=0; busy SHALL be registered, so it updates one cycle after the count changes.
REQ-020 Hazard check latency SHALL be: an issue at edge N causes stall to assert, for a dependent check, in the cycle after edge N.

Reset
REQ-021 rst=1 SHALL asynchronously clear all counts to 0 and drive stall=0 (all chk inputs masked), busy=0 and underflow_err=0.
REQ-022 Reset asserted mid-operation SHALL discard all pending state; events in the reset cycle SHALL be ignored.

Structure
REQ-023 The opcode constants (STORE, BRANCH, LOAD, OP, OP_IMM, JAL, JALR, LUI, AUIPC) and the count width SHALL live in the shared riscv package.
REQ-024 The per-register counter, with inc/dec inputs, saturation and underflow detect, SHALL be sub-module scoreboard_entry, instantiated 31 times.

Verification
REQ-025 Reset, then issue rd=5 opcode LOAD; next cycle check rs1=5 valid -> stall=1, busy=1; wb rd=5; next cycle -> stall=0, busy=0.
REQ-026 Issue rd=0 OP, then issue rd=7 STORE -> counts unchanged, stall=0 for chk rs1=0 and rs2=7.
REQ-027 Issue rd=3 in 3 consecutive cycles, then a 4th issue rd=3 -> stall=1, count stays 3; one wb rd=3 -> the 4th issue is accepted, count=3.
REQ-028 With count[9]=1, same-cycle issue rd=9 and wb rd=9 -> count[9]=1; same-cycle wb rd=9 and kill rd=9 -> count[9]=0, underflow_err=1.
REQ-029 Issue rd=12; kill rd=12 -> count 0, underflow_err=0; a further wb rd=12 -> underflow_err=1 and stays 1 until rst.
REQ-030 Assert rst asynchronously between edges with counts nonzero -> stall=0, busy=0 and underflow_err=0 immediately.
